// File: rtl/rrf_allocator_if.sv
// rtl/rrf_allocator_if.sv - dispatch/commit bus between the rename allocator and its neighbours
interface rrf_allocator_if #(
  parameter int RRF_SEL = 6
);
  // dispatch requests and commit feedback
  logic               req1;
  logic               req2;
  logic               stall_dp;
  logic [1:0]         comnum;
  logic [RRF_SEL-1:0] comptr;
  logic               prmiss;

  // grants and allocator state
  logic               dp1;
  logic               dp2;
  logic [RRF_SEL-1:0] dp1_addr;
  logic [RRF_SEL-1:0] dp2_addr;
  logic               allocatable;
  logic [RRF_SEL-1:0] dispatchptr;
  logic [RRF_SEL:0]   rrf_freenum;
  logic [31:0]        stall_cycles;
  logic [31:0]        alloc_total;

  // allocator side
  modport slave (
    input  req1, req2, stall_dp, comnum, comptr, prmiss,
    output dp1, dp2, dp1_addr, dp2_addr, allocatable, dispatchptr, rrf_freenum,
           stall_cycles, alloc_total
  );

  // dispatch / reorder-buffer side
  modport master (
    output req1, req2, stall_dp, comnum, comptr, prmiss,
    input  dp1, dp2, dp1_addr, dp2_addr, allocatable, dispatchptr, rrf_freenum,
           stall_cycles, alloc_total
  );
endinterface

// File: rtl/rrf_allocator.sv
// rtl/rrf_allocator.sv - RRF/ROB entry allocator, two grants per cycle, mispredict rollback (stats: RRF_ALLOC_STATS_EN)
module rrf_allocator #(
  parameter int RRF_SEL = 6,
  parameter int RRF_NUM = 64
) (
  input  logic           i_clk,
  input  logic           i_reset,
  rrf_allocator_if.slave bus
);

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  localparam logic [RRF_SEL:0]   LP_NUM      = (RRF_SEL+1)'(RRF_NUM);
  localparam logic [RRF_SEL+1:0] LP_NUM_WIDE = (RRF_SEL+2)'(RRF_NUM);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [RRF_SEL-1:0] r_dispatchptr;
  logic [RRF_SEL-1:0] w_dispatchptr_nxt;
  logic [RRF_SEL:0]   r_freenum;
  logic [RRF_SEL:0]   w_freenum_nxt;

  logic [1:0]         w_reqnum;
  logic [1:0]         w_allocnum;
  logic               w_req_legal;
  logic               w_allocatable;
  logic               w_dp1;
  logic               w_dp2;
  logic [RRF_SEL+1:0] w_free_run;
  logic [RRF_SEL+1:0] w_free_rec;

  assign w_reqnum    = {1'b0, bus.req1} + {1'b0, bus.req2};
  assign w_req_legal = bus.req1 | ~bus.req2;

  // All-or-nothing: a pair is granted only if both entries fit.
  assign w_allocatable = (r_state == RUN) &&
                         (r_freenum >= (RRF_SEL+1)'(w_reqnum)) &&
                         !bus.prmiss;

  assign w_dp1 = bus.req1 & w_allocatable & ~bus.stall_dp & w_req_legal & ~i_reset;
  assign w_dp2 = bus.req2 & w_allocatable & ~bus.stall_dp & w_req_legal & ~i_reset;
  assign w_allocnum = {1'b0, w_dp1} + {1'b0, w_dp2};

  // Two extra bits so underflow and overflow of the free count stay visible.
  assign w_free_run = (RRF_SEL+2)'(r_freenum) + (RRF_SEL+2)'(bus.comnum)
                    - (RRF_SEL+2)'(w_allocnum);
  assign w_free_rec = (RRF_SEL+2)'(r_freenum) + (RRF_SEL+2)'(bus.comnum);

  // Next-state, next pointer and next free count; a mispredict overrides everything.
  always_comb begin
    w_state_nxt       = r_state;
    w_dispatchptr_nxt = r_dispatchptr;
    w_freenum_nxt     = r_freenum;
    if (bus.prmiss) begin
      w_state_nxt       = RECOVER;
      w_dispatchptr_nxt = bus.comptr;
      w_freenum_nxt     = LP_NUM;
    end else begin
      case (r_state)
        RUN: begin
          w_dispatchptr_nxt = r_dispatchptr + (RRF_SEL)'(w_allocnum);
          w_freenum_nxt     = w_free_run[RRF_SEL:0];
        end
        RECOVER: begin
          w_state_nxt   = RUN;
          w_freenum_nxt = (w_free_rec > LP_NUM_WIDE) ? LP_NUM : w_free_rec[RRF_SEL:0];
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  // State, pointer and free-count registers; reset beats mispredict.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= RUN;
      r_dispatchptr <= '0;
      r_freenum     <= LP_NUM;
    end else begin
      r_state       <= w_state_nxt;
      r_dispatchptr <= w_dispatchptr_nxt;
      r_freenum     <= w_freenum_nxt;
    end
  end

  assign bus.dp1         = w_dp1;
  assign bus.dp2         = w_dp2;
  assign bus.dp1_addr    = r_dispatchptr;
  assign bus.dp2_addr    = r_dispatchptr + (RRF_SEL)'(1);
  assign bus.allocatable = w_allocatable;
  assign bus.dispatchptr = r_dispatchptr;
  assign bus.rrf_freenum = r_freenum;

`ifdef RRF_ALLOC_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_alloc_total;

  // Blocked-request and granted-entry counters; upstream stalls are not our blocking.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cycles <= '0;
      r_alloc_total  <= '0;
    end else begin
      if ((r_state == RUN) && (w_reqnum != 2'd0) && !w_dp1 && !w_dp2 && !bus.stall_dp)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      r_alloc_total <= r_alloc_total + 32'(w_allocnum);
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.alloc_total  = r_alloc_total;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.alloc_total  = 32'd0;
`endif

  // req2 is only meaningful together with req1.
  a_req2_needs_req1: assert property (@(posedge i_clk) disable iff (i_reset)
    !(bus.req2 && !bus.req1));

  // Commit feedback must never push the free count outside 0..RRF_NUM.
  a_free_in_range: assert property (@(posedge i_clk) disable iff (i_reset)
    ((r_state == RUN) && !bus.prmiss) |-> (!w_free_run[RRF_SEL+1] && (w_free_run <= LP_NUM_WIDE)));

endmodule
